// File: rtl/four_bank_mem_if.sv
// Request/response bundle for the four-bank memory: requester drives address,
// data and strobes; the memory returns read data, stall, error and bank status.
interface four_bank_mem_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        wr;
    logic        rd;
    logic [15:0] DataOut;
    logic        DataOut_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output Addr, DataIn, wr, rd,
        input  DataOut, DataOut_valid, stall, busy, err
    );

    modport slave (
        input  Addr, DataIn, wr, rd,
        output DataOut, DataOut_valid, stall, busy, err
    );
endinterface

// File: rtl/four_bank_mem.sv
// Four interleaved 16-bit banks selected by Addr[2:1]; each access occupies its
// bank for three cycles, and reads return through a fixed two-stage pipeline.
module four_bank_mem #(
    parameter int ROWS = 8192
) (
    input  logic          clk,
    input  logic          rst,
    four_bank_mem_if.slave bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [15:0]   r_mem [4][ROWS];
    logic [1:0]    r_cnt [4];
    logic          r_s1Valid;
    logic [15:0]   r_s1Data;
    logic          r_s2Valid;
    logic [15:0]   r_s2Data;

    logic          w_req;
    logic          w_err;
    logic          w_legal;
    logic          w_stall;
    logic          w_accept;
    logic          w_acceptWr;
    logic          w_acceptRd;
    logic [1:0]    w_bank;
    logic [RW-1:0] w_row;
    logic [3:0]    w_busy;

    // Request decode: an illegal request is flagged and otherwise ignored.
    always_comb begin
        w_bank     = bus.Addr[2:1];
        w_row      = bus.Addr[3 +: RW];
        w_req      = bus.rd | bus.wr;
        w_err      = (bus.rd & bus.wr) | (w_req & bus.Addr[0]);
        w_legal    = (bus.rd ^ bus.wr) & ~bus.Addr[0];
        w_stall    = w_legal & w_busy[w_bank];
        w_accept   = w_legal & ~w_stall;
        w_acceptWr = w_accept & bus.wr;
        w_acceptRd = w_accept & bus.rd;
    end

    always_comb begin
        w_busy = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            w_busy[n] = (r_cnt[n] != 2'd0);
        end
    end

    // Loading 3 on accept keeps the bank busy for exactly the next three cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 4; n++) begin
                r_cnt[n] <= 2'd0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_accept && (w_bank == 2'(n))) begin
                    r_cnt[n] <= 2'd3;
                end else if (r_cnt[n] != 2'd0) begin
                    r_cnt[n] <= r_cnt[n] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_acceptWr) begin
            r_mem[w_bank][w_row] <= bus.DataIn;
        end
    end

    // Memory contents survive reset; only the in-flight read slots are flushed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= 16'h0000;
            r_s2Valid <= 1'b0;
            r_s2Data  <= 16'h0000;
        end else begin
            r_s1Valid <= w_acceptRd;
            r_s1Data  <= w_acceptRd ? r_mem[w_bank][w_row] : 16'h0000;
            r_s2Valid <= r_s1Valid;
            r_s2Data  <= r_s1Valid ? r_s1Data : 16'h0000;
        end
    end

    always_comb begin
        bus.DataOut       = r_s2Valid ? r_s2Data : 16'h0000;
        bus.DataOut_valid = r_s2Valid;
        bus.stall         = w_stall;
        bus.err           = w_err;
        bus.busy          = w_busy;
    end

    a_stallErrExclusive : assert property (@(posedge clk) disable iff (!rst)
        !(bus.stall && bus.err));
endmodule
